// File: rtl/treeval_pkg.sv
// Shared types and helpers for the tree expected-value evaluator.
package treeval_pkg;

  typedef enum logic [2:0] {
    FLD_PARENT = 3'd0,
    FLD_ACTION = 3'd1,
    FLD_STRAT  = 3'd2,
    FLD_REWARD = 3'd3,
    FLD_WEIGHT = 3'd4
  } field_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_COMMIT,
    S_FIN
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Action codes at or above the slot count mark a node to be skipped.
  function automatic logic action_ok(input logic [31:0] a, input int n);
    return a < $unsigned(n);
  endfunction

endpackage

// File: rtl/treeval_gen_action_select.sv
// Combinational valid-masked arg-max/arg-min over the action slots;
// ties resolve to the lower action index.
module action_select #(
  parameter int N_ACTIONS = 8,
  parameter int VAL_W     = 20,
  localparam int W_ACTION = $clog2(N_ACTIONS)
) (
  input  logic [N_ACTIONS*VAL_W-1:0] vals,
  input  logic [N_ACTIONS-1:0]       valid,
  input  logic                       maximize,
  output logic                       any,
  output logic [W_ACTION-1:0]        sel,
  output logic signed [VAL_W-1:0]    best
);

  localparam int NP = 1 << W_ACTION;

  always_comb begin : tree
    logic signed [VAL_W-1:0] t_val [2*NP];
    logic                    t_vld [2*NP];
    logic [W_ACTION-1:0]     t_idx [2*NP];
    logic                    left_wins;
    for (int i = 0; i < 2*NP; i++) begin
      t_val[i] = '0;
      t_vld[i] = 1'b0;
      t_idx[i] = '0;
    end
    left_wins = 1'b0;
    for (int i = 0; i < N_ACTIONS; i++) begin
      t_val[NP+i] = vals[i*VAL_W +: VAL_W];
      t_vld[NP+i] = valid[i];
      t_idx[NP+i] = W_ACTION'(i);
    end
    // Heap-ordered reduction: the left child always holds the lower indices.
    for (int i = NP - 1; i >= 1; i--) begin
      left_wins = t_vld[2*i] && (!t_vld[2*i+1] ||
                  (maximize ? (t_val[2*i] >= t_val[2*i+1]) : (t_val[2*i] <= t_val[2*i+1])));
      t_val[i] = left_wins ? t_val[2*i] : t_val[2*i+1];
      t_idx[i] = left_wins ? t_idx[2*i] : t_idx[2*i+1];
      t_vld[i] = t_vld[2*i] || t_vld[2*i+1];
    end
    any  = t_vld[1];
    sel  = t_idx[1];
    best = t_val[1];
  end

endmodule

// File: rtl/treeval_gen.sv
// Bottom-up expected-value evaluation of a loaded decision tree: children are
// accumulated per action into their parent, then reduced by max or min.
module treeval_gen
  import treeval_pkg::*;
#(
  parameter int N_NODES   = 1024,
  parameter int N_ACTIONS = 8,
  parameter int W_REWARD  = 10,
  parameter int W_WEIGHT  = 8,
  localparam int W_ADDR   = $clog2(N_NODES),
  localparam int W_ACTION = $clog2(N_ACTIONS),
  localparam int W_DATA   = max3(W_ADDR, W_REWARD, W_WEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [2:0]                 ld_field,
  input  logic [W_ADDR-1:0]          ld_addr,
  input  logic [W_DATA-1:0]          ld_data,
  input  logic [W_ADDR:0]            num_nodes,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic signed [W_REWARD-1:0] exp,
  output logic [W_ACTION-1:0]        act
);

  localparam int ACC_W  = W_REWARD + W_ADDR;
  localparam int PROD_W = W_REWARD + W_WEIGHT + 1;
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) <<< (W_WEIGHT - 2);
  localparam logic [W_ADDR-1:0] ONE   = W_ADDR'(1);
  localparam logic [W_ADDR:0]   MIN_N = (W_ADDR+1)'(2);
  localparam logic [W_ADDR:0]   MAX_N = (W_ADDR+1)'(N_NODES);

  logic [W_ADDR-1:0]          par_mem   [N_NODES];
  logic [W_DATA-1:0]          act_mem   [N_NODES];
  logic                       strat_mem [N_NODES];
  logic signed [W_REWARD-1:0] rew_mem   [N_NODES];
  logic [W_WEIGHT-1:0]        wt_mem    [N_NODES];

  state_e                     state;
  logic [W_ADDR-1:0]          idx, grp;
  logic signed [ACC_W-1:0]    slot_acc [N_ACTIONS];
  logic [N_ACTIONS-1:0]       slot_vld;

  logic [W_DATA-1:0]          cur_act;
  logic                       cur_ok, grp_end, start_ok;
  logic [W_ACTION-1:0]        slot;
  logic [W_ADDR:0]            last_idx;
  logic signed [PROD_W-1:0]   prod, term;
  logic signed [31:0]         acc_sum, best_sat;
  logic [N_ACTIONS*ACC_W-1:0] vals;
  logic                       sel_any;
  logic [W_ACTION-1:0]        sel_idx;
  logic signed [ACC_W-1:0]    sel_best;
  logic signed [W_REWARD-1:0] commit_val;

  assign cur_act    = act_mem[idx];
  assign cur_ok     = action_ok(32'(cur_act), N_ACTIONS);
  assign slot       = cur_act[W_ACTION-1:0];
  assign prod       = PROD_W'(rew_mem[idx]) * PROD_W'($signed({1'b0, wt_mem[idx]}));
  assign term       = (prod + RND) >>> (W_WEIGHT - 1);
  assign acc_sum    = sat_w(32'(slot_acc[slot]) + 32'(term), ACC_W);
  assign grp_end    = (idx == ONE) || (par_mem[idx - ONE] != grp);
  assign start_ok   = (num_nodes >= MIN_N) && (num_nodes <= MAX_N);
  assign last_idx   = num_nodes - (W_ADDR+1)'(1);
  assign best_sat   = sat_w(32'(sel_best), W_REWARD);
  assign commit_val = W_REWARD'(best_sat);

  always_comb begin
    vals = '0;
    for (int i = 0; i < N_ACTIONS; i++) vals[i*ACC_W +: ACC_W] = slot_acc[i];
  end

  action_select #(.N_ACTIONS(N_ACTIONS), .VAL_W(ACC_W)) u_select (
    .vals     (vals),
    .valid    (slot_vld),
    .maximize (strat_mem[grp]),
    .any      (sel_any),
    .sel      (sel_idx),
    .best     (sel_best)
  );

  // Node storage: loader writes in IDLE, commit writes the group result back.
  always_ff @(posedge clk) begin
    if (rst && ld_valid && ld_ready) begin
      case (ld_field)
        FLD_PARENT: par_mem[ld_addr]   <= ld_data[W_ADDR-1:0];
        FLD_ACTION: act_mem[ld_addr]   <= ld_data;
        FLD_STRAT:  strat_mem[ld_addr] <= ld_data[0];
        FLD_REWARD: rew_mem[ld_addr]   <= ld_data[W_REWARD-1:0];
        FLD_WEIGHT: wt_mem[ld_addr]    <= ld_data[W_WEIGHT-1:0];
        default: ;
      endcase
    end else if (rst && state == S_COMMIT && sel_any) begin
      rew_mem[grp] <= commit_val;
      if (grp == '0) act_mem[0] <= W_DATA'(sel_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_ACCUM && cur_ok)
      slot_acc[slot] <= slot_vld[slot] ? ACC_W'(acc_sum) : ACC_W'(term);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      exp      <= '0;
      act      <= '0;
      ld_ready <= 1'b1;
      slot_vld <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy     <= 1'b1;
          ld_ready <= 1'b0;
          err      <= !start_ok;
          done     <= !start_ok;
          idx      <= last_idx[W_ADDR-1:0];
          state    <= start_ok ? S_CLEAR : S_FIN;
        end
        S_CLEAR: begin
          slot_vld <= '0;
          grp      <= par_mem[idx];
          state    <= S_ACCUM;
        end
        S_ACCUM: begin
          if (cur_ok) slot_vld[slot] <= 1'b1;
          else        err <= 1'b1;
          if (grp_end) state <= S_COMMIT;
          else         idx   <= idx - ONE;
        end
        S_COMMIT: begin
          if (idx == ONE) begin
            state <= S_FIN;
            done  <= 1'b1;
            // Root result is being written this same edge, so forward it.
            if (sel_any && grp == '0) begin
              exp <= commit_val;
              act <= sel_idx;
            end else begin
              exp <= rew_mem[0];
              act <= act_mem[0][W_ACTION-1:0];
            end
          end else begin
            idx   <= idx - ONE;
            state <= S_CLEAR;
          end
        end
        S_FIN: begin
          busy     <= 1'b0;
          ld_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_treeval_gen.sv
// Bench for treeval_gen: directed cases plus random trees against a
// group-by-group reference model of the evaluation.
module tb_treeval_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [2:0]        ld_field;
  logic [9:0]        ld_addr;
  logic [9:0]        ld_data;
  logic [10:0]       num_nodes;
  logic              start;
  logic              busy, done, err;
  logic signed [9:0] dut_exp;
  logic [2:0]        act;

  int compared   = 0;
  int mismatched = 0;
  int cur_exp    = 0;
  int cur_act    = 0;

  int m_par [1024];
  int m_act [1024];
  int m_str [1024];
  int m_rew [1024];
  int m_wt  [1024];

  treeval_gen dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_field  (ld_field),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .num_nodes (num_nodes),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .exp       (dut_exp),
    .act       (act)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic load(input int f, input int a, input int d);
    ld_valid = 1'b1;
    ld_field = 3'(f);
    ld_addr  = 10'(a);
    ld_data  = 10'(d);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic set_node(input int i, input int p, input int a, input int s,
                          input int r, input int w);
    m_par[i] = p; m_act[i] = a; m_str[i] = s; m_rew[i] = r; m_wt[i] = w;
    load(0, i, p);
    load(1, i, a);
    load(2, i, s);
    load(3, i, r);
    load(4, i, w);
  endtask

  // Reference: walk contiguous sibling runs from the last node down,
  // sum rounded weighted rewards per action, pick best, clamp to 10 bits.
  task automatic model_eval(input int n, output int e_exp, output int e_act,
                            output int e_err, output int e_lat);
    int i, g, p, t, best, besta;
    int sum [8];
    bit v [8];
    if (n < 2 || n > 1024) begin
      e_exp = cur_exp; e_act = cur_act; e_err = 1; e_lat = 1;
      return;
    end
    i = n - 1; g = 0; e_err = 0;
    while (i >= 1) begin
      p = m_par[i];
      g++;
      for (int a = 0; a < 8; a++) begin sum[a] = 0; v[a] = 0; end
      while (i >= 1 && m_par[i] == p) begin
        if (m_act[i] >= 8) e_err = 1;
        else begin
          t = (m_rew[i] * m_wt[i] + 64) >>> 7;
          sum[m_act[i]] += t;
          v[m_act[i]] = 1;
        end
        i--;
      end
      besta = -1; best = 0;
      for (int a = 0; a < 8; a++)
        if (v[a] && (besta < 0 || (m_str[p] != 0 ? sum[a] > best : sum[a] < best))) begin
          best = sum[a]; besta = a;
        end
      if (besta >= 0) begin
        m_rew[p] = best > 511 ? 511 : (best < -512 ? -512 : best);
        if (p == 0) m_act[0] = besta;
      end
    end
    e_exp = m_rew[0]; e_act = m_act[0] % 8; e_lat = (n - 1) + 2 * g + 1;
  endtask

  task automatic run(input string tag, input int n, input int e_exp, input int e_act,
                     input int e_err, input int e_lat);
    int c;
    num_nodes = 11'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    if (e_lat > 1) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ld_ready_busy"}, ld_ready, 0);
    end
    while (!done && c < 300) begin
      tick();
      c++;
    end
    check({tag, "_latency"}, c, e_lat);
    check({tag, "_err"}, err, e_err);
    check({tag, "_exp"}, dut_exp, e_exp);
    check({tag, "_act"}, act, e_act);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    cur_exp = e_exp;
    cur_act = e_act;
  endtask

  initial begin
    int e_exp, e_act, e_err, e_lat, n, p, seen;
    rst = 1'b0; ld_valid = 1'b0; ld_field = '0; ld_addr = '0; ld_data = '0;
    num_nodes = '0; start = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_exp", dut_exp, 0);
    check("rst_act", act, 0);
    check("rst_ld_ready", ld_ready, 1);
    rst = 1'b1;
    tick();

    set_node(0, 0, 0, 1, 0, 0);
    set_node(1, 0, 0, 0, 100, 128);
    set_node(2, 0, 1, 0, -50, 128);
    run("max_basic", 3, 100, 0, 0, 5);

    set_node(0, 0, 0, 0, 0, 0);
    run("min_basic", 3, -50, 1, 0, 5);

    set_node(0, 0, 0, 1, 0, 0);
    set_node(1, 0, 0, 0, 511, 128);
    set_node(2, 0, 0, 0, 511, 128);
    run("saturate", 3, 511, 0, 0, 5);

    set_node(1, 0, 0, 0, 3, 64);
    run("rounding", 2, 2, 0, 0, 4);

    set_node(1, 0, 0, 0, 40, 128);
    set_node(2, 0, 1, 0, 40, 128);
    run("tie_low", 3, 40, 0, 0, 5);

    set_node(1, 0, 8, 0, 100, 128);
    set_node(2, 0, 1, 0, 40, 128);
    run("bad_action", 3, 40, 1, 1, 5);

    run("n_one", 1, cur_exp, cur_act, 1, 1);
    run("n_zero", 0, cur_exp, cur_act, 1, 1);
    run("n_over", 1025, cur_exp, cur_act, 1, 1);

    for (int i = 0; i < 10; i++) set_node(i, 0, i % 8, 1, 7 * i, 100);
    num_nodes = 11'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ld_ready", ld_ready, 1);
    check("abort_exp", dut_exp, 0);
    seen = 0;
    repeat (20) begin
      tick();
      seen = seen | int'(done);
    end
    check("abort_no_done", seen, 0);
    cur_exp = 0;
    cur_act = 0;

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(2, 24);
      set_node(0, 0, $urandom_range(0, 7), $urandom_range(0, 1),
               int'($urandom_range(0, 1023)) - 512, $urandom_range(0, 255));
      p = 0;
      for (int i = 1; i < n; i++) begin
        if (p < i - 1 && $urandom_range(0, 2) == 0) p = $urandom_range(p + 1, i - 1);
        set_node(i, p,
                 ($urandom_range(0, 15) == 0) ? 8 + $urandom_range(0, 7) : $urandom_range(0, 7),
                 $urandom_range(0, 1),
                 int'($urandom_range(0, 1023)) - 512,
                 $urandom_range(0, 255));
      end
      model_eval(n, e_exp, e_act, e_err, e_lat);
      run($sformatf("rand%0d", t), n, e_exp, e_act, e_err, e_lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
